// File: rtl/cpec_pkg.sv
// Shared CPEC constants and helpers, imported by the encoder and the bit packer.
package cpec_pkg;

    localparam int CPEC_MAX_BITS = 40;
    localparam int CPEC_SIZE_W   = 6;
    localparam int CPEC_FILL_W   = 7;

    localparam logic [1:0] ST_ACCEPT = 2'd0;
    localparam logic [1:0] ST_EMIT   = 2'd1;
    localparam logic [1:0] ST_TAIL   = 2'd2;

    typedef enum logic [1:0] {
        PK_ACCEPT = ST_ACCEPT,
        PK_EMIT   = ST_EMIT,
        PK_TAIL   = ST_TAIL
    } pk_state_e;

    // Field lengths beyond the widest CPEC field are treated as the widest field.
    function automatic logic [CPEC_SIZE_W-1:0] clamp_size(input logic [CPEC_SIZE_W-1:0] size);
        logic [CPEC_SIZE_W-1:0] max_size;
        max_size = CPEC_SIZE_W'(CPEC_MAX_BITS);
        return (size > max_size) ? max_size : size;
    endfunction

endpackage

// File: rtl/cpec_bit_packer_if.sv
// Field-in / word-out stream bundle of the CPEC bit packer.
interface cpec_bit_packer_if #(
    parameter int OUT_W = 16
) ();

    logic                                  in_valid;
    logic                                  in_ready;
    logic [cpec_pkg::CPEC_MAX_BITS-1:0]    in_data;
    logic [cpec_pkg::CPEC_SIZE_W-1:0]      in_size;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [OUT_W-1:0]                      out_word;
    logic                                  out_last;

    modport master (
        output in_valid, in_data, in_size, out_ready,
        input  in_ready, out_valid, out_word, out_last
    );

    modport slave (
        input  in_valid, in_data, in_size, out_ready,
        output in_ready, out_valid, out_word, out_last
    );

endinterface

// File: rtl/cpec_field_aligner.sv
// Masks a right-aligned CPEC field to its length and places it just below the
// bits already held in the left-justified accumulator.
module cpec_field_aligner
    import cpec_pkg::*;
#(
    parameter int ACC_W = 56
) (
    input  logic [CPEC_MAX_BITS-1:0] data_i,
    input  logic [CPEC_SIZE_W-1:0]   size_i,
    input  logic [CPEC_FILL_W-1:0]   fill_i,
    output logic [CPEC_SIZE_W-1:0]   size_o,
    output logic [ACC_W-1:0]         field_o
);

    localparam int SH_W = 8;

    logic [CPEC_SIZE_W-1:0]   size_s;
    logic [CPEC_MAX_BITS-1:0] mask_s;
    logic [SH_W-1:0]          shift_s;
    logic [ACC_W-1:0]         ext_s;

    // Mask off bits at or above the field length, then left-justify under the fill.
    always_comb begin
        size_s  = clamp_size(size_i);
        mask_s  = {CPEC_MAX_BITS{1'b1}} >> (7'(CPEC_MAX_BITS) - {1'b0, size_s});
        ext_s   = ACC_W'(data_i & mask_s);
        // Only meaningful while fill < OUT_W; the result is unused otherwise.
        shift_s = SH_W'(ACC_W) - {1'b0, fill_i} - {2'b00, size_s};
        field_o = ext_s << shift_s;
        size_o  = size_s;
    end

endmodule

// File: rtl/cpec_bit_packer.sv
// Packs variable-length CPEC fields MSB-first into OUT_W-bit words; a flush
// drains the remainder as a zero-padded word tagged last.
module cpec_bit_packer
    import cpec_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int MAX_IN = CPEC_MAX_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    output logic              busy,
    cpec_bit_packer_if.slave  bus
);

    localparam int                     ACC_W   = OUT_W + MAX_IN;
    localparam logic [CPEC_FILL_W-1:0] OUT_W_F = CPEC_FILL_W'(OUT_W);
    localparam logic [OUT_W-1:0]       ONES    = {OUT_W{1'b1}};

    pk_state_e              state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [CPEC_FILL_W-1:0] fill_q, fill_d;
    logic                   flush_q, flush_d;
    logic [OUT_W-1:0]       word_d;

    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [OUT_W-1:0]       out_word_q;
    logic                   out_last_q;
    logic                   busy_q;

    logic                   accept_s;
    logic                   pop_s;
    logic [CPEC_SIZE_W-1:0] size_s;
    logic [ACC_W-1:0]       field_s;

    assign accept_s = bus.in_valid & in_ready_q;
    assign pop_s    = bus.out_ready & out_valid_q;

    cpec_field_aligner #(
        .ACC_W (ACC_W)
    ) u_aligner (
        .data_i  (bus.in_data),
        .size_i  (bus.in_size),
        .fill_i  (fill_q),
        .size_o  (size_s),
        .field_o (field_s)
    );

    // Next accumulator, fill, flush-pending and state; the state is always
    // re-derived from the new fill so an illegal encoding recovers in one cycle.
    always_comb begin
        acc_d   = acc_q;
        fill_d  = fill_q;
        flush_d = flush_q | flush;
        state_d = PK_ACCEPT;
        word_d  = '0;
        case (state_q)
            PK_ACCEPT: begin
                if (accept_s) begin
                    acc_d  = acc_q | field_s;
                    fill_d = fill_q + CPEC_FILL_W'(size_s);
                end else begin
                    acc_d  = acc_q;
                end
            end
            PK_EMIT: begin
                if (pop_s) begin
                    acc_d  = acc_q << OUT_W;
                    fill_d = fill_q - OUT_W_F;
                end else begin
                    acc_d  = acc_q;
                end
            end
            PK_TAIL: begin
                if (pop_s) begin
                    acc_d   = '0;
                    fill_d  = '0;
                    flush_d = 1'b0;
                end else begin
                    acc_d   = acc_q;
                end
            end
            default: begin
                acc_d   = '0;
                fill_d  = '0;
                flush_d = 1'b0;
            end
        endcase

        // Nothing left to drain: a pending flush retires without a word.
        flush_d = flush_d & (fill_d != '0);

        if (fill_d >= OUT_W_F) begin
            state_d = PK_EMIT;
        end else if (flush_d) begin
            state_d = PK_TAIL;
        end else begin
            state_d = PK_ACCEPT;
        end

        if (state_d == PK_TAIL) begin
            word_d = acc_d[ACC_W-1 -: OUT_W] & ~(ONES >> fill_d);
        end else begin
            word_d = acc_d[ACC_W-1 -: OUT_W];
        end
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PK_ACCEPT;
            acc_q       <= '0;
            fill_q      <= '0;
            flush_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            flush_q     <= flush_d;
            in_ready_q  <= (state_d == PK_ACCEPT);
            out_valid_q <= (state_d != PK_ACCEPT);
            out_word_q  <= word_d;
            out_last_q  <= (state_d == PK_TAIL);
            busy_q      <= (fill_d != '0) | flush_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_cpec_bit_packer.sv
// Directed and randomized bench for cpec_bit_packer (OUT_W=16) against a
// bit-queue model of the packed stream.
module tb_cpec_bit_packer;

    localparam int OUT_W = 16;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    logic busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bit model_q[$];

    cpec_bit_packer_if #(.OUT_W(OUT_W)) bus ();

    cpec_bit_packer #(.OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Next OUT_W bits of the reference stream, zero-padded when fewer remain.
    task automatic model_pop(input logic [OUT_W-1:0] w, input logic l);
        logic [OUT_W-1:0] e;
        int n;
        e = '0;
        n = model_q.size();
        for (int i = 0; i < OUT_W; i++) begin
            if (i < n) e[OUT_W-1-i] = model_q[i];
        end
        check("word_nonempty", (n > 0), 1'b1);
        check("word", w, e);
        check("last", l, (n < OUT_W));
        for (int i = 0; i < OUT_W; i++) begin
            if (model_q.size() > 0) void'(model_q.pop_front());
        end
    endtask

    task automatic cycle();
        logic             acc_f, pop_f, l;
        logic [OUT_W-1:0] w;
        logic [39:0]      d;
        int               sz;
        acc_f = bus.in_valid && bus.in_ready;
        pop_f = bus.out_valid && bus.out_ready;
        w     = bus.out_word;
        l     = bus.out_last;
        d     = bus.in_data;
        sz    = int'(bus.in_size);
        if (sz > 40) sz = 40;
        @(posedge clk);
        #1;
        if (rst) begin
            model_q.delete();
        end else begin
            if (pop_f) model_pop(w, l);
            if (acc_f) begin
                for (int i = sz - 1; i >= 0; i--) model_q.push_back(d[i]);
            end
        end
    endtask

    task automatic send(input logic [39:0] data, input int size);
        int k;
        k = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_size  = 6'(size);
        while (!bus.in_ready && k < 50) begin
            cycle();
            k++;
        end
        check("send_timeout", (k < 50), 1'b1);
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_word();
        int k;
        k = 0;
        bus.out_ready = 1'b1;
        while (!bus.out_valid && k < 50) begin
            cycle();
            k++;
        end
        check("pop_timeout", (k < 50), 1'b1);
        cycle();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int sent, cyc, k, fired;
        bus.in_valid  = 1'b0;
        bus.in_data   = 40'h0;
        bus.in_size   = 6'd0;
        bus.out_ready = 1'b0;

        // reset state
        cycle();
        cycle();
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_word", bus.out_word, 16'h0000);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        cycle();
        check("post_rst_in_ready", bus.in_ready, 1'b1);

        // four nibbles back-to-back
        send(40'hA, 4);
        send(40'hB, 4);
        send(40'hC, 4);
        send(40'hD, 4);
        check("abcd_valid", bus.out_valid, 1'b1);
        check("abcd_word", bus.out_word, 16'hABCD);
        cycle();
        check("abcd_in_ready_held", bus.in_ready, 1'b0);
        pop_word();
        check("abcd_in_ready_after", bus.in_ready, 1'b1);

        // one 40-bit field
        send(40'h123456789A, 40);
        check("w40_first", bus.out_word, 16'h1234);
        pop_word();
        check("w40_second", bus.out_word, 16'h5678);
        pop_word();
        check("w40_in_ready", bus.in_ready, 1'b1);
        check("w40_busy_fill8", busy, 1'b1);

        // flush the remaining 8 bits
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("tail_valid", bus.out_valid, 1'b1);
        check("tail_last", bus.out_last, 1'b1);
        check("tail_word", bus.out_word, 16'h9A00);
        check("tail_in_ready", bus.in_ready, 1'b0);
        pop_word();
        check("tail_busy_after", busy, 1'b0);
        check("tail_valid_after", bus.out_valid, 1'b0);

        // backpressure
        send(40'hBEEF, 16);
        for (int i = 0; i < 5; i++) begin
            check("stall_word", bus.out_word, 16'hBEEF);
            check("stall_in_ready", bus.in_ready, 1'b0);
            check("stall_valid", bus.out_valid, 1'b1);
            cycle();
        end
        pop_word();

        // size-0 skip field, upper data bits ignored
        send(40'hF, 4);
        send(40'hFFFFFFFFFF, 0);
        send(40'hFFFFFF0FFF, 12);
        check("skip_word", bus.out_word, 16'hFFFF);
        pop_word();

        // reset discards a partial word
        send(40'hABC, 12);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_mid_valid", bus.out_valid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        send(40'h5, 4);
        send(40'h678, 12);
        check("rst_mid_word", bus.out_word, 16'h5678);
        pop_word();

        // flush alongside an input, a repeated flush, and a flush with nothing held
        bus.in_valid = 1'b1;
        bus.in_data  = 40'h3;
        bus.in_size  = 6'd2;
        flush = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_in_word", bus.out_word, 16'hC000);
        check("flush_in_last", bus.out_last, 1'b1);
        pop_word();
        check("flush_in_busy", busy, 1'b0);
        check("flush_in_valid", bus.out_valid, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_empty_valid", bus.out_valid, 1'b0);
        check("flush_empty_busy", busy, 1'b0);
        check("flush_empty_ready", bus.in_ready, 1'b1);

        // oversize length clamps to 40
        send(40'hFEDCBA9876, 63);
        pop_word();
        pop_word();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        pop_word();

        // randomized fields with random stalls
        sent = 0;
        cyc  = 0;
        while (sent < 150 && cyc < 8000) begin
            if (!bus.in_valid && ($urandom % 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = {8'($urandom), 32'($urandom)};
                bus.in_size  = 6'($urandom_range(0, 47));
            end
            bus.out_ready = (($urandom % 4) != 0);
            fired = int'(bus.in_valid && bus.in_ready);
            cycle();
            if (fired != 0) begin
                sent++;
                bus.in_valid = 1'b0;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("rand_sent", sent, 150);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        k = 0;
        while (busy && k < 500) begin
            cycle();
            k++;
        end
        bus.out_ready = 1'b0;
        check("rand_drain_timeout", (k < 500), 1'b1);
        check("rand_model_empty", model_q.size(), 0);
        check("rand_idle_valid", bus.out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
